// File: rtl/fmac_pipe_if.sv
// Handshake bundle for fmac_pipe: operand stream in, frame result out.
interface fmac_pipe_if #(
   parameter int WIDTH = 16
);
   logic             i_valid;
   logic             i_last;
   logic [WIDTH-1:0] i_multiplicand;
   logic [WIDTH-1:0] i_multiplier;
   logic             i_ovr;
   logic             o_ready;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_result;
   logic             o_ovr;

   modport slave (
      input  i_valid, i_last, i_multiplicand, i_multiplier, i_ovr, i_ready,
      output o_ready, o_valid, o_result, o_ovr
   );

   modport master (
      output i_valid, i_last, i_multiplicand, i_multiplier, i_ovr, i_ready,
      input  o_ready, o_valid, o_result, o_ovr
   );
endinterface

// File: rtl/fmac_pipe.sv
// Four-stage signed fixed-point multiply-accumulate emitting one saturated result per frame.
// Optional macro FMAC_ROUND_EN selects round-half-up; otherwise results truncate toward -inf.
module fmac_pipe #(
   parameter int WIDTH    = 16,
   parameter int FRAC     = 7,
   parameter int MAX_TAPS = 32
) (
   input logic        i_clk,
   input logic        i_rst,
   fmac_pipe_if.slave bus
);
   localparam int G     = $clog2(MAX_TAPS);
   localparam int PW    = 2 * WIDTH;
   localparam int ACC_W = PW + G;
   localparam int EXT_W = ACC_W + 1;

   localparam logic signed [EXT_W-1:0] HALF =
      {{(EXT_W-1){1'b0}}, 1'b1} << (FRAC - 1);
   localparam logic signed [EXT_W-1:0] SAT_MAX =
      {{(EXT_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] SAT_MIN =
      {{(EXT_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] RES_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] RES_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic                    stall;

   logic                    s1_valid_q, s1_valid_d;
   logic                    s1_last_q, s1_last_d;
   logic                    s1_ovr_q, s1_ovr_d;
   logic signed [WIDTH-1:0] s1_a_q, s1_a_d;
   logic signed [WIDTH-1:0] s1_b_q, s1_b_d;

   logic                    s2_valid_q, s2_valid_d;
   logic                    s2_last_q, s2_last_d;
   logic                    s2_ovr_q, s2_ovr_d;
   logic signed [PW-1:0]    s2_prod_q, s2_prod_d;

   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    frame_ovr_q, frame_ovr_d;
   logic                    fin_valid_q, fin_valid_d;
   logic signed [ACC_W-1:0] fin_q, fin_d;
   logic                    fin_ovr_q, fin_ovr_d;

   logic                    o_valid_q, o_valid_d;
   logic [WIDTH-1:0]        o_result_q, o_result_d;
   logic                    o_ovr_q, o_ovr_d;

   logic signed [PW-1:0]    a_ext;
   logic signed [PW-1:0]    b_ext;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] sum;
   logic                    acc_ovf;
   logic                    frame_flag;
   logic signed [EXT_W-1:0] fin_ext;
   logic signed [EXT_W-1:0] rnd;
   logic signed [EXT_W-1:0] shf;
   logic                    sat_hi;
   logic                    sat_lo;

   // A held result freezes the whole pipe; ready never depends on i_valid.
   assign stall        = o_valid_q && !bus.i_ready;
   assign bus.o_ready  = !i_rst && !stall;
   assign bus.o_valid  = o_valid_q;
   assign bus.o_result = o_result_q;
   assign bus.o_ovr    = o_ovr_q;

   assign a_ext    = PW'(s1_a_q);
   assign b_ext    = PW'(s1_b_q);
   assign prod_ext = ACC_W'(s2_prod_q);
   assign sum      = acc_q + prod_ext;
   assign acc_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                     (sum[ACC_W-1] != acc_q[ACC_W-1]);
   assign frame_flag = frame_ovr_q | s2_ovr_q | acc_ovf;

   assign fin_ext = EXT_W'(fin_q);
`ifdef FMAC_ROUND_EN
   assign rnd = fin_ext + HALF;
`else
   assign rnd = fin_ext;
`endif
   assign shf    = rnd >>> FRAC;
   assign sat_hi = shf > SAT_MAX;
   assign sat_lo = shf < SAT_MIN;

   // S1: operand capture
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_last_d  = s1_last_q;
      s1_ovr_d   = s1_ovr_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      if (!stall) begin
         s1_valid_d = bus.i_valid;
         if (bus.i_valid) begin
            s1_last_d = bus.i_last;
            s1_ovr_d  = bus.i_ovr;
            s1_a_d    = bus.i_multiplicand;
            s1_b_d    = bus.i_multiplier;
         end else begin
            s1_last_d = 1'b0;
            s1_ovr_d  = 1'b0;
         end
      end else begin
         s1_valid_d = s1_valid_q;
      end
   end

   // S2: full-precision product
   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_last_d  = s2_last_q;
      s2_ovr_d   = s2_ovr_q;
      s2_prod_d  = s2_prod_q;
      if (!stall) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_last_d = s1_last_q;
            s2_ovr_d  = s1_ovr_q;
            s2_prod_d = a_ext * b_ext;
         end else begin
            s2_last_d = 1'b0;
            s2_ovr_d  = 1'b0;
         end
      end else begin
         s2_valid_d = s2_valid_q;
      end
   end

   // S3: the last beat diverts the sum to fin and restarts acc, so frames can abut
   always_comb begin
      acc_d       = acc_q;
      frame_ovr_d = frame_ovr_q;
      fin_valid_d = fin_valid_q;
      fin_d       = fin_q;
      fin_ovr_d   = fin_ovr_q;
      if (!stall) begin
         fin_valid_d = 1'b0;
         if (s2_valid_q) begin
            if (s2_last_q) begin
               fin_d       = sum;
               fin_ovr_d   = frame_flag;
               fin_valid_d = 1'b1;
               acc_d       = '0;
               frame_ovr_d = 1'b0;
            end else begin
               acc_d       = sum;
               frame_ovr_d = frame_flag;
            end
         end else begin
            acc_d = acc_q;
         end
      end else begin
         fin_valid_d = fin_valid_q;
      end
   end

   // S4: scale, saturate and present the frame result
   always_comb begin
      o_valid_d  = o_valid_q;
      o_result_d = o_result_q;
      o_ovr_d    = o_ovr_q;
      if (!stall) begin
         o_valid_d = fin_valid_q;
         if (fin_valid_q) begin
            if (sat_hi) begin
               o_result_d = RES_MAX;
            end else if (sat_lo) begin
               o_result_d = RES_MIN;
            end else begin
               o_result_d = shf[WIDTH-1:0];
            end
            o_ovr_d = fin_ovr_q | sat_hi | sat_lo;
         end else begin
            o_result_d = o_result_q;
         end
      end else begin
         o_valid_d = o_valid_q;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_ovr_q    <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s2_valid_q  <= 1'b0;
         s2_last_q   <= 1'b0;
         s2_ovr_q    <= 1'b0;
         s2_prod_q   <= '0;
         acc_q       <= '0;
         frame_ovr_q <= 1'b0;
         fin_valid_q <= 1'b0;
         fin_q       <= '0;
         fin_ovr_q   <= 1'b0;
         o_valid_q   <= 1'b0;
         o_result_q  <= '0;
         o_ovr_q     <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_last_q   <= s1_last_d;
         s1_ovr_q    <= s1_ovr_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s2_valid_q  <= s2_valid_d;
         s2_last_q   <= s2_last_d;
         s2_ovr_q    <= s2_ovr_d;
         s2_prod_q   <= s2_prod_d;
         acc_q       <= acc_d;
         frame_ovr_q <= frame_ovr_d;
         fin_valid_q <= fin_valid_d;
         fin_q       <= fin_d;
         fin_ovr_q   <= fin_ovr_d;
         o_valid_q   <= o_valid_d;
         o_result_q  <= o_result_d;
         o_ovr_q     <= o_ovr_d;
      end
   end
endmodule
